// File: rtl/fb_fetch_if.sv
//----------------------------------------------------------------------------
// fb_fetch_if : memory read port and pixel FIFO write port of the frame-buffer
//               fetch scheduler.
// Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

interface fb_fetch_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic [3:0]  mem_req_len;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic [6:0]  fifo_level;
  logic        fifo_wr_en;
  logic [31:0] fifo_wr_data;
  logic        fifo_flush;

  modport master (
    output mem_req_valid, mem_req_addr, mem_req_len,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, fifo_level,
    output fifo_wr_en, fifo_wr_data, fifo_flush
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, mem_req_len,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, fifo_level,
    input  fifo_wr_en, fifo_wr_data, fifo_flush
  );
endinterface

`default_nettype wire

// File: rtl/fb_fetch_ctrl.sv
//----------------------------------------------------------------------------
// fb_fetch_ctrl : frame-buffer fetch scheduler, credit-throttled burst reads
//                 into the pixel FIFO. Optional macro FB_FETCH_UNDERRUN_CNT_EN
//                 adds a saturating display underrun counter.
// Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

module fb_fetch_ctrl #(
  parameter int FB_WORDS   = 196608,
  parameter int FIFO_DEPTH = 64,
  parameter int BURST_LEN  = 8,
  parameter int MAX_OUTST  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_enable,
  input  logic [31:0] cfg_base,
  input  logic        frame_start,
  fb_fetch_if.master  bus,
  output logic        busy,
  output logic        frame_done,
  output logic        frame_late
`ifdef FB_FETCH_UNDERRUN_CNT_EN
  ,
  input  logic        pix_underrun,
  output logic [15:0] underrun_cnt
`endif
);

  localparam int WL_W  = $clog2(FB_WORDS + 1);
  localparam int IF_W  = $clog2(FIFO_DEPTH + 1);
  localparam int OS_W  = $clog2(MAX_OUTST + 1);
  localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FRAME = 2'd1,
    FETCH      = 2'd2,
    DRAIN      = 2'd3
  } state_t;

  state_t            state;
  logic [31:0]       cur_addr;
  logic [WL_W-1:0]   words_left;
  logic [IF_W-1:0]   inflight_words;
  logic [OS_W-1:0]   outst;
  logic [3:0]        len_q [MAX_OUTST];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [3:0]        beat_cnt;
  logic              wr_stage;
  logic [31:0]       wr_data;
  logic              flush_q;

  logic [3:0]        req_len;
  logic signed [15:0] credit;
  logic              req_valid;
  logic              accept;
  logic              head_done;
  logic              enter_fetch;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
  endfunction

  // Words already committed (in flight or in the write stage) count against FIFO space.
  assign req_len   = (words_left >= WL_W'(BURST_LEN)) ? 4'(BURST_LEN) : 4'(words_left);
  assign credit    = 16'(FIFO_DEPTH) - 16'(bus.fifo_level) - 16'(inflight_words) - 16'(wr_stage);
  assign req_valid = (state == FETCH) && cfg_enable && (words_left != '0) &&
                     (credit >= $signed(16'(req_len))) && (outst < OS_W'(MAX_OUTST));
  assign accept    = req_valid && bus.mem_req_ready;
  assign head_done = bus.mem_rsp_valid && (beat_cnt == len_q[rd_ptr] - 4'd1);
  assign enter_fetch = (state == WAIT_FRAME) && cfg_enable && frame_start;

  assign bus.mem_req_valid = req_valid;
  assign bus.mem_req_addr  = cur_addr;
  assign bus.mem_req_len   = req_len;
  assign bus.fifo_wr_en    = wr_stage;
  assign bus.fifo_wr_data  = wr_data;
  assign bus.fifo_flush    = flush_q;
  assign busy              = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cur_addr       <= '0;
      words_left     <= '0;
      inflight_words <= '0;
      outst          <= '0;
      for (int i = 0; i < MAX_OUTST; i++) len_q[i] <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      beat_cnt       <= '0;
      wr_stage       <= 1'b0;
      wr_data        <= '0;
      flush_q        <= 1'b0;
      frame_done     <= 1'b0;
      frame_late     <= 1'b0;
    end else begin
      wr_stage <= bus.mem_rsp_valid;
      wr_data  <= bus.mem_rsp_data;
      flush_q    <= 1'b0;
      frame_done <= 1'b0;

      // Burst-length FIFO lets outst retire only when a whole burst has returned.
      if (accept) begin
        len_q[wr_ptr] <= req_len;
        wr_ptr        <= ptr_inc(wr_ptr);
      end
      if (bus.mem_rsp_valid) begin
        if (head_done) begin
          beat_cnt <= '0;
          rd_ptr   <= ptr_inc(rd_ptr);
        end else begin
          beat_cnt <= beat_cnt + 4'd1;
        end
      end
      inflight_words <= inflight_words + (accept ? IF_W'(req_len) : '0)
                                       - (bus.mem_rsp_valid ? IF_W'(1) : '0);
      outst <= outst + OS_W'(accept) - OS_W'(head_done);

      case (state)
        IDLE: begin
          if (cfg_enable) state <= WAIT_FRAME;
        end
        WAIT_FRAME: begin
          if (!cfg_enable) begin
            state <= IDLE;
          end else if (frame_start) begin
            state      <= FETCH;
            cur_addr   <= cfg_base;
            words_left <= WL_W'(FB_WORDS);
            flush_q    <= 1'b1;
          end
        end
        FETCH: begin
          if (frame_start) frame_late <= 1'b1;
          if (accept) begin
            cur_addr   <= cur_addr + (32'(req_len) << 2);
            words_left <= words_left - WL_W'(req_len);
          end
          if (!cfg_enable || (words_left == '0)) state <= DRAIN;
        end
        DRAIN: begin
          if (frame_start) frame_late <= 1'b1;
          if (inflight_words == '0) begin
            state      <= cfg_enable ? WAIT_FRAME : IDLE;
            frame_done <= (words_left == '0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FB_FETCH_UNDERRUN_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun_cnt <= '0;
    end else if (enter_fetch) begin
      underrun_cnt <= '0;
    end else if (((state == FETCH) || (state == DRAIN)) && pix_underrun &&
                 (underrun_cnt != 16'hFFFF)) begin
      underrun_cnt <= underrun_cnt + 16'd1;
    end
  end
`else
  logic unused_enter_fetch;
  assign unused_enter_fetch = enter_fetch;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fb_fetch_ctrl.sv
//----------------------------------------------------------------------------
// tb_fb_fetch_ctrl : bench for fb_fetch_ctrl with a 20-word frame, a one-word-
//                    per-cycle memory responder and a pixel-word scoreboard.
// Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

module tb_fb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_enable = 1'b0;
  logic [31:0] cfg_base = '0;
  logic        frame_start = 1'b0;
  logic        busy, frame_done, frame_late;
`ifdef FB_FETCH_UNDERRUN_CNT_EN
  logic        pix_underrun = 1'b0;
  logic [15:0] underrun_cnt;
`endif

  fb_fetch_if bus();

  always #5 clk = ~clk;

  fb_fetch_ctrl #(
    .FB_WORDS(20), .FIFO_DEPTH(64), .BURST_LEN(8), .MAX_OUTST(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_enable(cfg_enable), .cfg_base(cfg_base),
    .frame_start(frame_start), .bus(bus.master), .busy(busy),
    .frame_done(frame_done), .frame_late(frame_late)
`ifdef FB_FETCH_UNDERRUN_CNT_EN
    , .pix_underrun(pix_underrun), .underrun_cnt(underrun_cnt)
`endif
  );

  typedef struct { logic [31:0] addr; logic [3:0] len; } req_t;
  typedef struct { logic [6:0] level; logic exp_valid; logic [3:0] exp_len; } vec_t;

  req_t        exp_req [$];
  logic [31:0] exp_data[$];
  logic [31:0] pend    [$];
  int   errors = 0, checks = 0;
  int   wr_cnt = 0, done_cnt = 0;
  bit   rsp_auto = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory model: one response per cycle, then capture any handshake this cycle.
  initial begin
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (rsp_auto && rst_n && pend.size() > 0) begin
        logic [31:0] a, d;
        a = pend.pop_front();
        d = a ^ 32'h5A00_00C3;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = d;
        exp_data.push_back(d);
      end else begin
        bus.mem_rsp_valid = 1'b0;
      end
      if (rst_n && bus.mem_req_valid && bus.mem_req_ready) begin
        if (exp_req.size() == 0) begin
          checks++; errors++;
          $display("FAIL req_unexpected: got addr 0x%0h len %0d expected none",
                   bus.mem_req_addr, bus.mem_req_len);
        end else begin
          req_t e;
          e = exp_req.pop_front();
          chk("req_addr", bus.mem_req_addr, e.addr);
          chk("req_len", 32'(bus.mem_req_len), 32'(e.len));
        end
        for (int i = 0; i < int'(bus.mem_req_len); i++) pend.push_back(bus.mem_req_addr + 32'(4 * i));
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.fifo_wr_en) begin
        wr_cnt++;
        if (exp_data.size() == 0) begin
          checks++; errors++;
          $display("FAIL fifo_data: got 0x%0h expected none", bus.fifo_wr_data);
        end else begin
          chk("fifo_data", bus.fifo_wr_data, exp_data.pop_front());
        end
      end
      if (frame_done) done_cnt++;
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic push_frame_reqs(input logic [31:0] base);
    exp_req.push_back('{base, 4'd8});
    exp_req.push_back('{base + 32'h20, 4'd8});
    exp_req.push_back('{base + 32'h40, 4'd4});
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
  endtask

  task automatic wait_frame_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (frame_done) seen = 1'b1;
    end
    chk({name, "_frame_done_seen"}, 32'(seen), 32'd1);
    chk({name, "_words_before_done"}, 32'(wr_cnt), 32'd20);
  endtask

  vec_t tbl[6];

  initial begin
    int done0;
    bit went_idle;
    tbl[0] = '{7'd64, 1'b0, 4'd8};
    tbl[1] = '{7'd60, 1'b0, 4'd8};
    tbl[2] = '{7'd57, 1'b0, 4'd8};
    tbl[3] = '{7'd56, 1'b1, 4'd8};
    tbl[4] = '{7'd33, 1'b1, 4'd8};
    tbl[5] = '{7'd0,  1'b1, 4'd8};
    bus.mem_req_ready = 1'b0;
    bus.fifo_level    = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_req_valid", 32'(bus.mem_req_valid), 0);
    chk("rst_req_addr", bus.mem_req_addr, 0);
    chk("rst_wr_en", 32'(bus.fifo_wr_en), 0);
    chk("rst_flush", 32'(bus.fifo_flush), 0);
    chk("rst_late", 32'(frame_late), 0);
    cyc();
    rst_n = 1'b1;

    // Full 20-word frame, FIFO always empty
    cfg_enable = 1'b1; cfg_base = 32'h1000; bus.mem_req_ready = 1'b1; rsp_auto = 1'b1;
    push_frame_reqs(32'h1000);
    cyc();
    wr_cnt = 0;
    pulse_start();
    @(negedge clk);
    chk("f1_flush", 32'(bus.fifo_flush), 1);
    wait_frame_done("f1");
    repeat (5) @(negedge clk);
    chk("f1_done_count", 32'(done_cnt), 1);
    chk("f1_req_left", 32'(exp_req.size()), 0);
    chk("f1_data_left", 32'(exp_data.size()), 0);
    chk("f1_busy_wait", 32'(busy), 1);

    // Credit table, then stalled request and simultaneous accept/response
    cyc();
    cfg_base = 32'h2000; bus.mem_req_ready = 1'b0; rsp_auto = 1'b0; bus.fifo_level = 7'd60;
    push_frame_reqs(32'h2000);
    wr_cnt = 0;
    pulse_start();
    @(negedge clk);
    chk("f2_flush", 32'(bus.fifo_flush), 1);
    for (int i = 0; i < 6; i++) begin
      cyc();
      bus.fifo_level = tbl[i].level;
`ifdef FB_FETCH_UNDERRUN_CNT_EN
      pix_underrun = (i < 3);
`endif
      @(negedge clk);
      chk($sformatf("credit_valid_lvl%0d", tbl[i].level), 32'(bus.mem_req_valid), 32'(tbl[i].exp_valid));
      chk($sformatf("credit_len_lvl%0d", tbl[i].level), 32'(bus.mem_req_len), 32'(tbl[i].exp_len));
    end
`ifdef FB_FETCH_UNDERRUN_CNT_EN
    chk("underrun_cnt3", 32'(underrun_cnt), 3);
`endif
    cyc(); bus.mem_req_ready = 1'b1;
    cyc(); bus.mem_req_ready = 1'b0;
    @(negedge clk);
    chk("inflight_after_b1", 32'(dut.inflight_words), 8);
    for (int i = 0; i < 5; i++) begin
      cyc();
      @(negedge clk);
      chk("stall_valid", 32'(bus.mem_req_valid), 1);
      chk("stall_addr", bus.mem_req_addr, 32'h2020);
      chk("stall_len", 32'(bus.mem_req_len), 8);
    end
    cyc(); bus.mem_req_ready = 1'b1; rsp_auto = 1'b1;
    cyc(); bus.mem_req_ready = 1'b0; rsp_auto = 1'b0;
    @(negedge clk);
    chk("inflight_acc_rsp", 32'(dut.inflight_words), 15);
    cyc(); bus.mem_req_ready = 1'b1; rsp_auto = 1'b1;
    wait_frame_done("f2");
    repeat (3) @(negedge clk);
    chk("f2_done_count", 32'(done_cnt), 2);
    chk("f2_data_left", 32'(exp_data.size()), 0);

    // Late frame_start, then disable mid-frame
    cyc();
    cfg_base = 32'h3000; bus.mem_req_ready = 1'b0;
    exp_req.push_back('{32'h3000, 4'd8});
    pulse_start();
`ifdef FB_FETCH_UNDERRUN_CNT_EN
    @(negedge clk);
    chk("underrun_cleared", 32'(underrun_cnt), 0);
`endif
    cyc();
    pulse_start();
    @(negedge clk);
    chk("late_set", 32'(frame_late), 1);
    chk("late_no_flush", 32'(bus.fifo_flush), 0);
    cyc(); bus.mem_req_ready = 1'b1;
    cyc(); cfg_enable = 1'b0;
    done0 = done_cnt;
    @(negedge clk);
    chk("disable_valid", 32'(bus.mem_req_valid), 0);
    went_idle = 1'b0;
    for (int i = 0; i < 100 && !went_idle; i++) begin
      @(negedge clk);
      if (!busy) went_idle = 1'b1;
    end
    chk("disable_idle", 32'(went_idle), 1);
    repeat (3) @(negedge clk);
    chk("disable_no_done", 32'(done_cnt), 32'(done0));
    chk("disable_late_sticky", 32'(frame_late), 1);
    chk("disable_req_left", 32'(exp_req.size()), 0);
    chk("disable_data_left", 32'(exp_data.size()), 0);

    // Asynchronous reset with three bursts outstanding
    cyc();
    cfg_enable = 1'b1; cfg_base = 32'h4000; rsp_auto = 1'b0; bus.mem_req_ready = 1'b1;
    push_frame_reqs(32'h4000);
    cyc();
    pulse_start();
    repeat (3) cyc();
    chk("outst_before_reset", 32'(dut.outst), 3);
    chk("busy_before_reset", 32'(busy), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_req_valid", 32'(bus.mem_req_valid), 0);
    chk("arst_req_len", 32'(bus.mem_req_len), 0);
    chk("arst_late", 32'(frame_late), 0);
    @(negedge clk);
    chk("arst_wr_en", 32'(bus.fifo_wr_en), 0);
    chk("arst_done", 32'(frame_done), 0);
    chk("arst_req_left", 32'(exp_req.size()), 0);
    pend.delete();
    exp_data.delete();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
